// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Holds the arbiter state encodings and the architectural widths used by every file.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic {
    WbArbNormal = 1'b0,
    WbArbForce  = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_aux_fifo.sv
// Synchronous FIFO holding queued aux results (destination + data).
// Pointers carry an extra wrap bit so a full FIFO is distinguishable from an empty one.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [REG_ADDR_W-1:0]     push_addr_i,
  input  logic [XLEN-1:0]           push_data_i,
  input  logic                      pop_i,
  output logic [REG_ADDR_W-1:0]     head_addr_o,
  output logic [XLEN-1:0]           head_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]            wptr_q, wptr_d;
  logic [AW:0]            rptr_q, rptr_d;
  logic [REG_ADDR_W-1:0]  addr_mem_q [DEPTH];
  logic [XLEN-1:0]        data_mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_i};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem_q[wptr_q[AW-1:0]] <= push_addr_i;
      data_mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign head_addr_o = addr_mem_q[rptr_q[AW-1:0]];
  assign head_data_o = data_mem_q[rptr_q[AW-1:0]];
  assign count_o     = wptr_q - rptr_q;
  assign full_o      = (count_o == (AW + 1)'(DEPTH));
  assign empty_o     = (wptr_q == rptr_q);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback pipe and a queued aux unit.
// Optional pending-destination bitmap is built when WB_SCOREBOARD_EN is defined.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned AUX_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wr_en_in,
  input  logic [REG_ADDR_W-1:0] pipe_rd_addr_in,
  input  logic [XLEN-1:0]       pipe_rd_value_in,
  output logic                  pipe_ready_out,
  input  logic                  aux_valid_in,
  input  logic [REG_ADDR_W-1:0] aux_rd_addr_in,
  input  logic [XLEN-1:0]       aux_rd_value_in,
  output logic                  aux_ready_out,
  output logic                  rf_wr_en_out,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_out,
  output logic [XLEN-1:0]       rf_rd_value_out,
  output logic                  aux_pending_out,
  output logic                  aux_drop_out,
  output logic [NUM_REGS-1:0]   aux_busy_out
);

  localparam int unsigned CW        = $clog2(AUX_DEPTH) + 1;
  localparam logic [3:0]  StarveLim = 4'(STARVE_LIMIT);

  wb_arb_state_e         state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]       rf_value_q, rf_value_d;
  logic                  drop_q, drop_d;

  logic                  pipe_req, aux_req, push, pop, same_rd;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;

  assign pipe_req = pipe_wr_en_in && (pipe_rd_addr_in != '0);
  assign aux_req  = !fifo_empty;
  assign same_rd  = (pipe_rd_addr_in == head_addr);
  // rd==0 results are accepted but never stored.
  assign push     = aux_valid_in && aux_ready_out && (aux_rd_addr_in != '0);

  wb_aux_fifo #(
    .DEPTH (AUX_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (aux_rd_addr_in),
    .push_data_i (aux_rd_value_in),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pop        = 1'b0;
    drop_d     = 1'b0;
    rf_wr_en_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_value_d = rf_value_q;
    case (state_q)
      WbArbNormal: begin
        if (pipe_req) begin
          rf_wr_en_d = 1'b1;
          rf_addr_d  = pipe_rd_addr_in;
          rf_value_d = pipe_rd_value_in;
          if (aux_req && same_rd) begin
            // Younger pipe write to the same rd makes the queued result stale.
            pop      = 1'b1;
            drop_d   = 1'b1;
            starve_d = '0;
          end else if (aux_req) begin
            starve_d = starve_q + 4'd1;
            if (starve_d >= StarveLim) state_d = WbArbForce;
          end else begin
            starve_d = '0;
          end
        end else if (aux_req) begin
          rf_wr_en_d = 1'b1;
          rf_addr_d  = head_addr;
          rf_value_d = head_data;
          pop        = 1'b1;
          starve_d   = '0;
        end else begin
          starve_d = '0;
        end
      end
      WbArbForce: begin
        if (aux_req) begin
          rf_wr_en_d = 1'b1;
          rf_addr_d  = head_addr;
          rf_value_d = head_data;
          pop        = 1'b1;
        end
        starve_d = '0;
        state_d  = WbArbNormal;
      end
      default: state_d = WbArbNormal;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WbArbNormal;
      starve_q   <= '0;
      rf_wr_en_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_value_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_value_q <= rf_value_d;
      drop_q     <= drop_d;
    end
  end

  assign pipe_ready_out  = (state_q == WbArbNormal);
  assign aux_ready_out   = !fifo_full;
  assign aux_pending_out = (fifo_count != '0);
  assign rf_wr_en_out    = rf_wr_en_q;
  assign rf_rd_addr_out  = rf_addr_q;
  assign rf_rd_value_out = rf_value_q;
  assign aux_drop_out    = drop_q;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle push of the popped rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop)  busy_d[head_addr]      = 1'b0;
    if (push) busy_d[aux_rd_addr_in] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign aux_busy_out = busy_q;
`else
  assign aux_busy_out = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default AUX_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en_in;
  logic [4:0]  pipe_rd_addr_in;
  logic [31:0] pipe_rd_value_in;
  logic        pipe_ready_out;
  logic        aux_valid_in;
  logic [4:0]  aux_rd_addr_in;
  logic [31:0] aux_rd_value_in;
  logic        aux_ready_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_rd_value_out;
  logic        aux_pending_out;
  logic        aux_drop_out;
  logic [31:0] aux_busy_out;

  wb_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .pipe_wr_en_in    (pipe_wr_en_in),
    .pipe_rd_addr_in  (pipe_rd_addr_in),
    .pipe_rd_value_in (pipe_rd_value_in),
    .pipe_ready_out   (pipe_ready_out),
    .aux_valid_in     (aux_valid_in),
    .aux_rd_addr_in   (aux_rd_addr_in),
    .aux_rd_value_in  (aux_rd_value_in),
    .aux_ready_out    (aux_ready_out),
    .rf_wr_en_out     (rf_wr_en_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_rd_value_out  (rf_rd_value_out),
    .aux_pending_out  (aux_pending_out),
    .aux_drop_out     (aux_drop_out),
    .aux_busy_out     (aux_busy_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] v;
  } wr_t;

  int  tests = 0;
  int  fails = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  drops = 0;
  int  stalls = 0;
  int  zero_wr = 0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en_out) wr_q.push_back({rf_rd_addr_out, rf_rd_value_out});
      if (rf_wr_en_out && rf_rd_addr_out == 5'd0) zero_wr++;
      if (aux_drop_out) drops++;
      if (!pipe_ready_out) stalls++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wr_en_in    = 1'b0;
    pipe_rd_addr_in  = '0;
    pipe_rd_value_in = '0;
    aux_valid_in     = 1'b0;
    aux_rd_addr_in   = '0;
    aux_rd_value_in  = '0;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] v);
    exp_q.push_back({a, v});
  endtask

  task automatic check_writes(input string tag, input int base);
    chk({tag, "_count"}, 64'(wr_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wr_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(wr_q[base+i].a), 64'(exp_q[i].a));
        chk($sformatf("%s_val%0d", tag, i), 64'(wr_q[base+i].v), 64'(exp_q[i].v));
      end
    end
    exp_q.delete();
  endtask

  int         base, d0, s0, g, pi, c_cyc;
  bit         c_done, p_acc, c_acc;
  logic [4:0] seq3 [9];

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 64'(rf_wr_en_out), 64'd0);
    chk("rst_pipe_ready", 64'(pipe_ready_out), 64'd1);
    chk("rst_aux_ready", 64'(aux_ready_out), 64'd1);
    chk("rst_pending", 64'(aux_pending_out), 64'd0);
    chk("rst_drop", 64'(aux_drop_out), 64'd0);
    chk("rst_busy", 64'(aux_busy_out), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // 1: two aux entries queued behind pipe writes, then asynchronous reset
    pipe_wr_en_in = 1'b1; pipe_rd_addr_in = 5'd1; pipe_rd_value_in = 32'h101;
    aux_valid_in = 1'b1; aux_rd_addr_in = 5'd3; aux_rd_value_in = 32'h33;
    cyc();
    pipe_rd_addr_in = 5'd2; pipe_rd_value_in = 32'h102;
    aux_rd_addr_in = 5'd4; aux_rd_value_in = 32'h44;
    cyc();
    idle();
    chk("t1_pre_pending", 64'(aux_pending_out), 64'd1);
    chk("t1_pre_full", 64'(aux_ready_out), 64'd0);
    chk("t1_pre_wr_en", 64'(rf_wr_en_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_wr_en", 64'(rf_wr_en_out), 64'd0);
    chk("t1_pending", 64'(aux_pending_out), 64'd0);
    chk("t1_aux_ready", 64'(aux_ready_out), 64'd1);
    chk("t1_busy", 64'(aux_busy_out), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t1_post_wr_en", 64'(rf_wr_en_out), 64'd0);
    chk("t1_post_pending", 64'(aux_pending_out), 64'd0);

    // 2: idle pipe, single aux result written two cycles after push
    base = wr_q.size();
    aux_valid_in = 1'b1; aux_rd_addr_in = 5'd5; aux_rd_value_in = 32'hDEADBEEF;
    cyc();
    idle();
    chk("t2_c1_pending", 64'(aux_pending_out), 64'd1);
    chk("t2_c1_wr_en", 64'(rf_wr_en_out), 64'd0);
    cyc();
    chk("t2_c2_wr_en", 64'(rf_wr_en_out), 64'd1);
    chk("t2_c2_addr", 64'(rf_rd_addr_out), 64'd5);
    chk("t2_c2_val", 64'(rf_rd_value_out), 64'hDEADBEEF);
    chk("t2_c2_pending", 64'(aux_pending_out), 64'd0);
    cyc();
    exp_wr(5'd5, 32'hDEADBEEF);
    check_writes("t2", base);

    // 3: starvation guard forces x9 in after four denied cycles
    base = wr_q.size();
    s0 = stalls;
    seq3 = '{5'd10, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    for (int i = 0; i < 9; i++) begin
      pipe_wr_en_in = 1'b1;
      pipe_rd_addr_in = seq3[i];
      pipe_rd_value_in = 32'h100 + 32'(seq3[i]);
      aux_valid_in = (i == 0);
      aux_rd_addr_in = 5'd9;
      aux_rd_value_in = 32'h99;
      g = 0;
      while (!pipe_ready_out && g < 20) begin
        cyc();
        aux_valid_in = 1'b0;
        g++;
      end
      if (g >= 20) chk("t3_ready_timeout", 64'(g), 64'd0);
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();
    exp_wr(5'd10, 32'h10A);
    for (int i = 1; i <= 4; i++) exp_wr(5'(i), 32'h100 + 32'(i));
    exp_wr(5'd9, 32'h99);
    for (int i = 5; i <= 8; i++) exp_wr(5'(i), 32'h100 + 32'(i));
    check_writes("t3", base);
    chk("t3_stalls", 64'(stalls - s0), 64'd1);
    chk("t3_pending", 64'(aux_pending_out), 64'd0);

    // 4: younger pipe write to x7 supersedes the queued aux x7
    base = wr_q.size();
    d0 = drops;
    pipe_wr_en_in = 1'b1; pipe_rd_addr_in = 5'd3; pipe_rd_value_in = 32'h103;
    aux_valid_in = 1'b1; aux_rd_addr_in = 5'd7; aux_rd_value_in = 32'h55;
    cyc();
    aux_valid_in = 1'b0;
    pipe_rd_addr_in = 5'd7; pipe_rd_value_in = 32'h11;
    chk("t4_c1_pending", 64'(aux_pending_out), 64'd1);
    chk("t4_c1_busy", 64'(aux_busy_out), SbEn ? 64'h80 : 64'd0);
    cyc();
    idle();
    chk("t4_c2_drop", 64'(aux_drop_out), 64'd1);
    chk("t4_c2_addr", 64'(rf_rd_addr_out), 64'd7);
    chk("t4_c2_val", 64'(rf_rd_value_out), 64'h11);
    chk("t4_c2_pending", 64'(aux_pending_out), 64'd0);
    chk("t4_c2_busy", 64'(aux_busy_out), 64'd0);
    cyc();
    chk("t4_c3_drop", 64'(aux_drop_out), 64'd0);
    cyc(); cyc();
    exp_wr(5'd3, 32'h103);
    exp_wr(5'd7, 32'h11);
    check_writes("t4", base);
    chk("t4_drops", 64'(drops - d0), 64'd1);

    // 5: FIFO full back-pressure with a busy pipe
    base = wr_q.size();
    pi = 1;
    c_done = 1'b0;
    c_cyc = -1;
    for (int cy = 0; cy < 20; cy++) begin
      pipe_wr_en_in = (pi <= 8);
      pipe_rd_addr_in = 5'(pi);
      pipe_rd_value_in = 32'h100 + 32'(pi);
      aux_valid_in = 1'b0;
      if (cy == 0) begin
        aux_valid_in = 1'b1; aux_rd_addr_in = 5'd11; aux_rd_value_in = 32'hA1;
      end else if (cy == 1) begin
        aux_valid_in = 1'b1; aux_rd_addr_in = 5'd12; aux_rd_value_in = 32'hB2;
      end else if (!c_done) begin
        aux_valid_in = 1'b1; aux_rd_addr_in = 5'd13; aux_rd_value_in = 32'hC3;
      end
      if (cy == 2) chk("t5_ready_full", 64'(aux_ready_out), 64'd0);
      p_acc = pipe_wr_en_in && pipe_ready_out;
      c_acc = (cy >= 2) && !c_done && aux_ready_out;
      cyc();
      if (p_acc) pi++;
      if (c_acc) begin
        c_done = 1'b1;
        c_cyc = cy;
      end
    end
    idle();
    cyc();
    chk("t5_c_accept_cycle", 64'(c_cyc), 64'd6);
    for (int i = 1; i <= 5; i++) exp_wr(5'(i), 32'h100 + 32'(i));
    exp_wr(5'd11, 32'hA1);
    for (int i = 6; i <= 8; i++) exp_wr(5'(i), 32'h100 + 32'(i));
    exp_wr(5'd12, 32'hB2);
    exp_wr(5'd13, 32'hC3);
    check_writes("t5", base);
    chk("t5_pending", 64'(aux_pending_out), 64'd0);

    // 6: rd==0 from both sources writes and queues nothing
    base = wr_q.size();
    pipe_wr_en_in = 1'b1; pipe_rd_addr_in = 5'd0; pipe_rd_value_in = 32'hFFFF;
    aux_valid_in = 1'b1; aux_rd_addr_in = 5'd0; aux_rd_value_in = 32'h1234;
    chk("t6_aux_ready", 64'(aux_ready_out), 64'd1);
    cyc();
    idle();
    chk("t6_pending", 64'(aux_pending_out), 64'd0);
    chk("t6_busy", 64'(aux_busy_out), 64'd0);
    chk("t6_wr_en", 64'(rf_wr_en_out), 64'd0);
    cyc();
    chk("t6_wr_en2", 64'(rf_wr_en_out), 64'd0);
    cyc();
    check_writes("t6", base);

    chk("no_rd0_write", 64'(zero_wr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
